// File: rtl/udp_tx_pkt_reader.sv
// udp_tx_pkt_reader
// Drains the UDP TX byte FIFO in fixed-size payload packets and hands them
// to the UDP/IP TX engine with a req/grant handshake, then streams one byte
// per cycle with tx_valid/tx_last.
// Optional build macro: UDP_TX_TIMEOUT_FLUSH_EN flushes a partial packet
// after TIMEOUT_CYCLES idle cycles with residual data in the FIFO.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a full packet (or a flush timeout)
// S_REQ   | tx_req held high, tx_len stable, waiting for tx_grant
// S_READ  | fifo_rd_en high for exactly tx_len cycles
// S_DRAIN | reads done, waiting for the FIFO latency to deliver tx_last
// S_GAP   | enforcing the inter-frame gap before the next request
module udp_tx_pkt_reader #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 64,
    parameter int RD_LATENCY = 2,
    parameter int IFG_CYCLES = 12
`ifdef UDP_TX_TIMEOUT_FLUSH_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_wr_en,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  tx_req,
    output logic [15:0]           tx_len,
    input  logic                  tx_grant,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_last,
    output logic                  underflow,
    output logic [15:0]           pkt_cnt
);

    localparam int OCC_W = ADDR_WIDTH + 1;
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(2 ** ADDR_WIDTH);
    localparam logic [OCC_W-1:0] OCC_PKT = OCC_W'(PKT_LEN);
    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [OCC_W-1:0]       occ;
    logic [15:0]            len_q;
    logic [15:0]            rd_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic [RD_LATENCY-1:0]  valid_pipe;
    logic [RD_LATENCY-1:0]  last_pipe;
    logic                   wr_acc;
    logic                   final_rd;
    logic                   full_ready;
    logic                   timeout;

    assign wr_acc     = fifo_wr_en & ~fifo_full;
    assign full_ready = (occ >= OCC_PKT);
    assign fifo_rd_en = (state_q == S_READ);
    assign tx_req     = (state_q == S_REQ);
    assign tx_len     = len_q;
    assign final_rd   = fifo_rd_en && (rd_cnt == 16'd1);
    assign tx_valid   = valid_pipe[RD_LATENCY-1];
    assign tx_last    = last_pipe[RD_LATENCY-1];
    // Read data only shows on the bus while it is qualified, so reset leaves it at 0.
    assign tx_data    = tx_valid ? fifo_rd_data : '0;

`ifdef UDP_TX_TIMEOUT_FLUSH_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] idle_cnt;
    logic            idle_run;

    // The idle timer only runs while a partial packet sits untouched in the FIFO.
    assign idle_run = (state_q == S_IDLE) && (occ != '0) && !full_ready && !fifo_wr_en;
    assign timeout  = idle_run && (idle_cnt == '0);

    // Idle down-counter; any write or leaving the partial condition reloads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
        end else if (!idle_run) begin
            idle_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
        end else if (idle_cnt != '0) begin
            idle_cnt <= idle_cnt - 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // FIFO occupancy: a simultaneous write and read cancel, count saturates at depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            case ({wr_acc, fifo_rd_en})
                2'b10:   if (occ != OCC_MAX) occ <= occ + 1'b1;
                2'b01:   if (occ != '0) occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a full packet always takes priority over a flush.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (full_ready || timeout) state_d = S_REQ;
            S_REQ:   if (tx_grant) state_d = S_READ;
            S_READ:  if (final_rd) state_d = S_DRAIN;
            S_DRAIN: if (tx_last) state_d = S_GAP;
            S_GAP:   if (gap_cnt == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Length is captured once on entry to REQ so later writes cannot change it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
        end else if (state_q == S_IDLE && state_d == S_REQ) begin
            len_q <= full_ready ? 16'(PKT_LEN) : 16'(occ);
        end
    end

    // Read down-counter: loaded at grant, terminal count 1 marks the final read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
        end else if (state_q == S_REQ && tx_grant) begin
            rd_cnt <= len_q;
        end else if (fifo_rd_en && rd_cnt != '0) begin
            rd_cnt <= rd_cnt - 1'b1;
        end
    end

    // Inter-frame gap down-counter, loaded as tx_last leaves the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (state_q == S_DRAIN && tx_last) begin
            gap_cnt <= GAP_LOAD;
        end else if (state_q == S_GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // Delay read strobe and final-read flag to line up with the FIFO read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_pipe <= '0;
            last_pipe  <= '0;
        end else begin
            valid_pipe[0] <= fifo_rd_en;
            last_pipe[0]  <= final_rd;
            for (int i = 1; i < RD_LATENCY; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
                last_pipe[i]  <= last_pipe[i-1];
            end
        end
    end

    // Packet counter (wraps) and sticky underflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt   <= '0;
            underflow <= 1'b0;
        end else begin
            if (tx_last) pkt_cnt <= pkt_cnt + 1'b1;
            if (fifo_rd_en && fifo_empty) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_udp_tx_pkt_reader.sv
// tb_udp_tx_pkt_reader
// Directed bench for udp_tx_pkt_reader with a behavioural 128-deep,
// output-registered (2-cycle) FIFO in front of it and an auto-granting
// UDP engine model behind it.
module tb_udp_tx_pkt_reader;

    localparam int PKT = 64;
    localparam int IFG = 12;
    localparam int LAT = 2;

    logic        clk_tb = 1'b0;
    logic        tb_rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        force_empty = 1'b0;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic        tx_req;
    logic [15:0] tx_len;
    logic        tx_grant = 1'b0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic        underflow;
    logic [15:0] pkt_cnt;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk_tb = ~clk_tb;

    udp_tx_pkt_reader dut (
        .clk          (clk_tb),
        .rst_n        (tb_rst),
        .fifo_wr_en   (wr_en),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .tx_req       (tx_req),
        .tx_len       (tx_len),
        .tx_grant     (tx_grant),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .underflow    (underflow),
        .pkt_cnt      (pkt_cnt)
    );

    // Behavioural FIFO, reset together with the block.
    logic [7:0] mem [0:127];
    logic [6:0] wptr, rptr;
    logic [8:0] mcnt;
    logic [7:0] d1, d2;
    logic       do_wr, do_rd;

    assign do_wr        = wr_en && (mcnt < 9'd128);
    assign do_rd        = fifo_rd_en && (mcnt != 9'd0);
    assign fifo_full    = (mcnt == 9'd128);
    assign fifo_empty   = (mcnt == 9'd0) || force_empty;
    assign fifo_rd_data = d2;

    always @(posedge clk_tb or negedge tb_rst) begin
        if (!tb_rst) begin
            wptr <= '0; rptr <= '0; mcnt <= '0; d1 <= '0; d2 <= '0;
        end else begin
            if (do_wr) begin
                mem[wptr] <= wr_data;
                wptr <= wptr + 1'b1;
            end
            if (do_rd) begin
                d1 <= mem[rptr];
                rptr <= rptr + 1'b1;
            end
            d2 <= d1;
            mcnt <= mcnt + 9'(do_wr) - 9'(do_rd);
        end
    end

    always @(posedge clk_tb) cyc <= cyc + 1;

    // Pre-edge capture of occupancy on simultaneous read/write cycles.
    logic       ov_flag = 1'b0;
    logic [7:0] occ_pre = '0;
    always @(posedge clk_tb) begin
        ov_flag <= wr_en && !fifo_full && fifo_rd_en;
        occ_pre <= dut.occ;
    end

    // Output monitor and UDP engine grant model.
    logic [7:0] rx_q[$];
    int         last_idx_q[$];
    int         last_cyc_q[$];
    int         rise_q[$];
    int         nvalid = 0;
    int         first_valid_cyc = 0;
    int         grant_cyc = 0;
    int         ov_seen = 0;
    int         ov_bad = 0;
    logic       req_d = 1'b0;
    logic       clr_mon = 1'b0;
    logic       grant_en = 1'b1;
    int         grant_delay = 0;
    int         req_age = 0;

    always @(negedge clk_tb) begin
        if (clr_mon) begin
            rx_q.delete(); last_idx_q.delete(); last_cyc_q.delete(); rise_q.delete();
            nvalid = 0; ov_seen = 0; ov_bad = 0;
        end else begin
            if (tx_valid) begin
                rx_q.push_back(tx_data);
                nvalid++;
                if (nvalid == 1) first_valid_cyc = cyc;
            end
            if (tx_last) begin
                last_idx_q.push_back(rx_q.size());
                last_cyc_q.push_back(cyc);
            end
            if (tx_req && !req_d) rise_q.push_back(cyc);
            if (ov_flag) begin
                ov_seen++;
                if (dut.occ !== occ_pre) ov_bad++;
            end
        end
        req_d = tx_req;
        if (grant_en && tx_req && !tx_grant) begin
            if (req_age >= grant_delay) begin
                tx_grant = 1'b1;
                grant_cyc = cyc;
            end else begin
                req_age++;
            end
        end else begin
            tx_grant = 1'b0;
            req_age = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        @(posedge clk_tb);
        clr_mon = 1'b1;
        @(posedge clk_tb);
        clr_mon = 1'b0;
    endtask

    task automatic write_bytes(input int n, input int start);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_tb);
            wr_en = 1'b1;
            wr_data = 8'(start + i);
        end
        @(negedge clk_tb);
        wr_en = 1'b0;
    endtask

    task automatic wait_req(input string tag, input int max);
        int k = 0;
        while (!tx_req && k < max) begin
            @(negedge clk_tb);
            k++;
        end
        check(tag, 32'(tx_req), 1);
    endtask

    task automatic wait_req_drop(input string tag, input int max);
        int k = 0;
        while (tx_req && k < max) begin
            @(negedge clk_tb);
            k++;
        end
        check(tag, 32'(tx_req), 0);
    endtask

    task automatic wait_pkts(input string tag, input int target, input int max);
        int k = 0;
        while (32'(pkt_cnt) != target && k < max) begin
            @(negedge clk_tb);
            k++;
        end
        check(tag, 32'(pkt_cnt), 32'(target));
    endtask

    task automatic check_bytes(input string tag, input int n);
        int bad = 0;
        check({tag, "_count"}, 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < rx_q.size(); i++) begin
            if (rx_q[i] !== 8'(i + 1)) bad++;
        end
        check({tag, "_data"}, 32'(bad), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        check("rst_ctrl", 32'({tx_valid, tx_last, tx_req, fifo_rd_en, underflow}), 0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 0);
        check("rst_tx_len", 32'(tx_len), 0);
        repeat (3) @(negedge clk_tb);
        tb_rst = 1'b1;

        // 1: one packet, grant 3 cycles after tx_req
        grant_delay = 3;
        clear_mon();
        write_bytes(PKT, 1);
        wait_req("t1_req", 20);
        check("t1_tx_len", 32'(tx_len), PKT);
        wait_pkts("t1_pkt_cnt", 1, 300);
        check_bytes("t1_bytes", PKT);
        check("t1_last_n", 32'(last_idx_q.size()), 1);
        check("t1_last_idx", (last_idx_q.size() > 0) ? 32'(last_idx_q[0]) : 0, PKT);
        check("t1_latency", 32'(first_valid_cyc - grant_cyc), LAT + 1);
        check("t1_underflow", 32'(underflow), 0);

        // 2: 128 bytes, immediate grants, inter-frame gap honoured
        grant_delay = 0;
        clear_mon();
        write_bytes(2 * PKT, 1);
        wait_pkts("t2_pkt_cnt", 3, 800);
        check_bytes("t2_bytes", 2 * PKT);
        check("t2_last_n", 32'(last_idx_q.size()), 2);
        check("t2_last_idx1", (last_idx_q.size() > 1) ? 32'(last_idx_q[1]) : 0, 2 * PKT);
        check("t2_rises", 32'(rise_q.size()), 2);
        check("t2_ifg", ((rise_q.size() > 1 && last_cyc_q.size() > 0) &&
                         (rise_q[1] - last_cyc_q[0] > IFG)) ? 32'd1 : 32'd0, 1);
        check("t2_occ", 32'(dut.occ), 0);

`ifndef UDP_TX_TIMEOUT_FLUSH_EN
        // 3: partial packet waits indefinitely without the flush feature
        clear_mon();
        write_bytes(PKT - 1, 1);
        repeat (5000) @(negedge clk_tb);
        check("t3_no_req", 32'(rise_q.size()), 0);
        check("t3_occ", 32'(dut.occ), PKT - 1);
        write_bytes(1, PKT);
        @(negedge clk_tb);
        check("t3_req_fast", 32'(tx_req), 1);
        wait_pkts("t3_pkt_cnt", 4, 300);
        check_bytes("t3_bytes", PKT);
`else
        // 4: flush of a 10-byte partial packet after the idle timeout
        begin
            int wcyc;
            clear_mon();
            write_bytes(10, 1);
            wcyc = cyc;
            wait_req("t4_req", 1200);
            check("t4_timeout", (rise_q.size() > 0 && rise_q[0] - wcyc >= 1023 &&
                                 rise_q[0] - wcyc <= 1026) ? 32'd1 : 32'd0, 1);
            check("t4_tx_len", 32'(tx_len), 10);
            wait_pkts("t4_pkt_cnt", 4, 300);
            check_bytes("t4_bytes", 10);
        end
`endif

        // 5: writes overlapping the read phase
        clear_mon();
        write_bytes(PKT, 1);
        wait_req("t5_req", 20);
        wait_req_drop("t5_req_drop", 20);
        write_bytes(PKT, PKT + 1);
        wait_pkts("t5_pkt_cnt", 6, 800);
        check_bytes("t5_bytes", 2 * PKT);
        check("t5_overlap_seen", (ov_seen > 0) ? 32'd1 : 32'd0, 1);
        check("t5_overlap_occ", 32'(ov_bad), 0);
        check("t5_occ", 32'(dut.occ), 0);

        // 6: reset on the 20th payload byte
        begin
            int k = 0;
            int t = 0;
            clear_mon();
            write_bytes(PKT, 1);
            while (k < 20 && t < 300) begin
                @(posedge clk_tb);
                #1;
                t++;
                if (tx_valid) k++;
            end
            check("t6_reached20", 32'(k), 20);
            tb_rst = 1'b0;
            #1;
            check("t6_rst_ctrl", 32'({tx_valid, tx_last, tx_req, fifo_rd_en, underflow}), 0);
            check("t6_rst_data", 32'(tx_data), 0);
            check("t6_rst_pkt_cnt", 32'(pkt_cnt), 0);
            check("t6_rst_tx_len", 32'(tx_len), 0);
            repeat (3) @(negedge clk_tb);
            tb_rst = 1'b1;
            repeat (100) @(negedge clk_tb);
            check("t6_no_last", 32'(last_idx_q.size()), 0);
            check("t6_state_idle", 32'(dut.state_q), 0);
            check("t6_occ", 32'(dut.occ), 0);
        end

        // 7: empty FIFO read sets sticky underflow
        clear_mon();
        write_bytes(PKT, 1);
        wait_req("t7_req", 20);
        wait_req_drop("t7_req_drop", 20);
        force_empty = 1'b1;
        @(negedge clk_tb);
        check("t7_underflow_set", 32'(underflow), 1);
        force_empty = 1'b0;
        wait_pkts("t7_pkt_cnt", 1, 300);
        repeat (50) @(negedge clk_tb);
        check("t7_underflow_sticky", 32'(underflow), 1);
        tb_rst = 1'b0;
        #1;
        check("t7_underflow_rst", 32'(underflow), 0);
        repeat (2) @(negedge clk_tb);
        tb_rst = 1'b1;
        repeat (5) @(negedge clk_tb);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
